// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths and the initiator state encoding.
package wb_pkg;

    localparam int WB_AW = 16;
    localparam int WB_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wb_io_master.sv
// Wishbone classic-cycle initiator for the J1 I/O port: one bus cycle per CPU strobe,
// ended by ack_i, a fixed wait (ack-less slaves) or a timeout.
module wb_io_master
    import wb_pkg::*;
#(
    parameter bit                USE_ACK    = 1'b1,
    parameter int                FIXED_WAIT = 1,
    parameter int                TIMEOUT    = 16,
    parameter logic [WB_DW-1:0]  ERR_DATA   = 16'hFFFF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cpu_rd,
    input  logic             i_cpu_wr,
    input  logic [WB_AW-1:0] i_cpu_addr,
    input  logic [WB_DW-1:0] i_cpu_wdata,
    output logic [WB_DW-1:0] o_cpu_rdata,
    output logic             o_cpu_busy,
    output logic             o_cpu_done,
    output logic             o_cpu_err,
    output logic             o_cyc,
    output logic             o_stb,
    output logic             o_we,
    output logic [WB_AW-1:0] o_adr,
    output logic [WB_DW-1:0] o_dat,
    output logic             o_sel,
    input  logic [WB_DW-1:0] i_dat,
    input  logic             i_ack
);

    localparam int            CW       = $clog2(max_int(TIMEOUT, FIXED_WAIT) + 1);
    localparam logic [CW-1:0] LAST_ACK = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] LAST_FIX = CW'(FIXED_WAIT - 1);

    wb_state_e        r_state;
    wb_state_e        w_state_next;
    logic [CW-1:0]    r_cnt;
    logic             r_we;
    logic             r_err;
    logic [WB_AW-1:0] r_adr;
    logic [WB_DW-1:0] r_dat;
    logic [WB_DW-1:0] r_rdata;
    logic             w_accept;
    logic             w_bus_end;
    logic             w_timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A write wins over a simultaneous read; ack_i wins over a same-cycle timeout.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_bus_end    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cpu_rd || i_cpu_wr) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_BUS;
                end
            end
            ST_BUS: begin
                if (USE_ACK) begin
                    if (i_ack) begin
                        w_bus_end = 1'b1;
                    end else if (r_cnt == LAST_ACK) begin
                        w_bus_end = 1'b1;
                        w_timeout = 1'b1;
                    end
                end else if (r_cnt == LAST_FIX) begin
                    w_bus_end = 1'b1;
                end
                if (w_bus_end) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_we  <= i_cpu_wr;
                r_adr <= i_cpu_addr;
                r_dat <= i_cpu_wdata;
            end
            // Counter only runs inside BUS and is cleared on exit, so it never wraps.
            if (r_state == ST_BUS && !w_bus_end) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (w_bus_end) begin
                r_err <= w_timeout;
                if (!r_we) begin
                    r_rdata <= w_timeout ? ERR_DATA : i_dat;
                end
            end
        end
    end

    assign o_cyc       = (r_state == ST_BUS);
    assign o_stb       = o_cyc;
    assign o_sel       = o_cyc;
    assign o_we        = o_cyc & r_we;
    assign o_adr       = r_adr;
    assign o_dat       = r_dat;
    assign o_cpu_busy  = (r_state == ST_BUS) || (r_state == ST_DONE);
    assign o_cpu_done  = (r_state == ST_DONE);
    assign o_cpu_err   = o_cpu_done & r_err;
    assign o_cpu_rdata = r_rdata;

endmodule

// File: tb/tb_wb_io_master.sv
// Bench for wb_io_master: three instances (ack-driven, fixed wait 1, fixed wait 3) share one
// CPU/bus stimulus; expectations come from per-transaction cycle-window arithmetic.
module tb_wb_io_master;

    localparam logic [15:0] ERR = 16'hFFFF;
    localparam int          TO  = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0, ack = 1'b0;
    logic [15:0] addr = '0, wdata = '0, dat = '0;

    logic [2:0]  busy, done, err, cyc, stb, we, sel;
    logic [15:0] rdata [3];
    logic [15:0] adr   [3];
    logic [15:0] dout  [3];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_rdata [3];
    logic [15:0] dat_seq   [20];

    always #5 clk = ~clk;

    wb_io_master #(.USE_ACK(1'b1), .FIXED_WAIT(1), .TIMEOUT(TO), .ERR_DATA(ERR)) dut_ack (
        .i_clk(clk), .i_rst_n(rst_n), .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr),
        .i_cpu_addr(addr), .i_cpu_wdata(wdata), .o_cpu_rdata(rdata[0]), .o_cpu_busy(busy[0]),
        .o_cpu_done(done[0]), .o_cpu_err(err[0]), .o_cyc(cyc[0]), .o_stb(stb[0]), .o_we(we[0]),
        .o_adr(adr[0]), .o_dat(dout[0]), .o_sel(sel[0]), .i_dat(dat), .i_ack(ack));

    wb_io_master #(.USE_ACK(1'b0), .FIXED_WAIT(1), .TIMEOUT(TO), .ERR_DATA(ERR)) dut_fw1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr),
        .i_cpu_addr(addr), .i_cpu_wdata(wdata), .o_cpu_rdata(rdata[1]), .o_cpu_busy(busy[1]),
        .o_cpu_done(done[1]), .o_cpu_err(err[1]), .o_cyc(cyc[1]), .o_stb(stb[1]), .o_we(we[1]),
        .o_adr(adr[1]), .o_dat(dout[1]), .o_sel(sel[1]), .i_dat(dat), .i_ack(ack));

    wb_io_master #(.USE_ACK(1'b0), .FIXED_WAIT(3), .TIMEOUT(TO), .ERR_DATA(ERR)) dut_fw3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr),
        .i_cpu_addr(addr), .i_cpu_wdata(wdata), .o_cpu_rdata(rdata[2]), .o_cpu_busy(busy[2]),
        .o_cpu_done(done[2]), .o_cpu_err(err[2]), .o_cyc(cyc[2]), .o_stb(stb[2]), .o_we(we[2]),
        .o_adr(adr[2]), .o_dat(dout[2]), .o_sel(sel[2]), .i_dat(dat), .i_ack(ack));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Request in cycle 0; DUT d holds stb for cycles 1..len[d], pulses done at len[d]+1.
    task automatic run_txn(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                           input int ack_at, input bit busy_req, input int len0, input bit err0);
        int          len [3];
        bit          e   [3];
        bit          is_rd;
        bit          in_bus;
        logic [5:0]  exp_v, act_v;
        len[0] = len0; e[0] = err0;
        len[1] = 1;    e[1] = 1'b0;
        len[2] = 3;    e[2] = 1'b0;
        is_rd = rd && !wr;
        for (int d = 0; d < 3; d++) begin
            if (is_rd) exp_rdata[d] = e[d] ? ERR : dat_seq[len[d]];
        end
        cpu_rd = rd; cpu_wr = wr; addr = a; wdata = wd; ack = 1'b0; dat = dat_seq[0];
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                in_bus = (c <= len[d]);
                exp_v  = {in_bus, in_bus, in_bus, c <= len[d] + 1, c == len[d] + 1,
                          (c == len[d] + 1) && e[d]};
                act_v  = {cyc[d], stb[d], sel[d], busy[d], done[d], err[d]};
                chk($sformatf("ctl d%0d c%0d a=%h", d, c, a), 64'(act_v), 64'(exp_v));
                if (in_bus)
                    chk($sformatf("bus d%0d c%0d", d, c), {31'd0, we[d], adr[d], dout[d]},
                        {31'd0, wr, a, wd});
                if (c == len[d] + 1)
                    chk($sformatf("rdata d%0d c%0d", d, c), 64'(rdata[d]), 64'(exp_rdata[d]));
            end
            if (c == 1 && busy_req) begin
                cpu_rd = 1'b0; cpu_wr = 1'b1; addr = ~a; wdata = ~wd;
            end else begin
                cpu_rd = 1'b0; cpu_wr = 1'b0;
            end
            ack = (c == ack_at);
            dat = dat_seq[c];
        end
        ack = 1'b0;
        for (int d = 0; d < 3; d++)
            chk($sformatf("rdata_held d%0d a=%h", d, a), 64'(rdata[d]), 64'(exp_rdata[d]));
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] dat;
        int          ack_at;
        bit          busy_req;
        int          exp_len;
        bit          exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vt [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_at, len0;
        bit rd, wr;
        vt[0] = '{1'b0, 1'b1, 16'hF001, 16'h0041, 16'h1234,  2, 1'b0,  2, 1'b0, 16'h0000};
        vt[1] = '{1'b1, 1'b0, 16'hF000, 16'h0000, 16'h005A,  1, 1'b0,  1, 1'b0, 16'h005A};
        vt[2] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h1111,  1, 1'b0,  1, 1'b0, 16'h005A};
        vt[3] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'h7777,  0, 1'b0, 16, 1'b1, 16'hFFFF};
        vt[4] = '{1'b1, 1'b1, 16'h2222, 16'h3333, 16'h4444,  3, 1'b1,  3, 1'b0, 16'hFFFF};
        vt[5] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0ABC, 16, 1'b0, 16, 1'b0, 16'h0ABC};
        vt[6] = '{1'b0, 1'b1, 16'h0003, 16'h5555, 16'h9999,  0, 1'b0, 16, 1'b1, 16'h0ABC};
        vt[7] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h0DEF, 17, 1'b0, 16, 1'b1, 16'hFFFF};

        // Reset state
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_ctl d%0d", d),
                64'({cyc[d], stb[d], sel[d], we[d], busy[d], done[d], err[d]}), 64'd0);
            chk($sformatf("reset_data d%0d", d), {16'd0, rdata[d], adr[d], dout[d]}, 64'd0);
            exp_rdata[d] = 16'h0000;
        end
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 20; c++) dat_seq[c] = vt[i].dat;
            run_txn(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].ack_at, vt[i].busy_req,
                    vt[i].exp_len, vt[i].exp_err);
            chk($sformatf("table_rdata v%0d", i), 64'(rdata[0]), 64'(vt[i].exp_rdata));
        end

        // Reset asserted in the middle of a bus cycle
        for (int c = 0; c < 20; c++) dat_seq[c] = 16'h0000;
        cpu_rd = 1'b1; addr = 16'h0A0A;
        @(negedge clk);
        cpu_rd = 1'b0;
        chk("pre_reset_cyc", 64'(cyc), 64'(3'b111));
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_ctl", 64'({cyc, stb, sel, busy, done, we}), 64'd0);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midreset_data d%0d", d), {16'd0, rdata[d], adr[d], dout[d]}, 64'd0);
            exp_rdata[d] = 16'h0000;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("post_reset_idle k%0d", k), 64'({cyc, busy, done}), 64'd0);
        end
        run_txn(1'b1, 1'b0, 16'h0B0B, 16'h0000, 0, 1'b0, TO, 1'b1);

        // Randomised transactions with per-cycle read data and stray acks
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < 20; c++) dat_seq[c] = 16'($urandom);
            rd     = 1'($urandom);
            wr     = 1'($urandom) | ~rd;
            ack_at = int'($urandom_range(0, 19));
            len0   = (ack_at >= 1 && ack_at <= TO) ? ack_at : TO;
            run_txn(rd, wr, 16'($urandom), 16'($urandom), ack_at, 1'($urandom), len0,
                    !(ack_at >= 1 && ack_at <= TO));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
